// File: rtl/bs_rtr_rr_bcast.sv
// Round-robin packet bus: pops one packet from the granted source FIFO and pushes it to the
// destination port(s) named in its top byte. Optional broadcast via macro BUS_BCAST_EN.
//   state     | meaning
//   S_IDLE    | waiting for any pndng, picks next source round-robin
//   S_GRANT   | pop strobe to granted source, packet captured into pkt_buf
//   S_DELIVER | push strobe(s) to destination(s), or count a drop
module bs_rtr_rr_bcast #(
  parameter int         DRVRS    = 4,
  parameter int         PCKG_SZ  = 16,
  parameter logic [7:0] BCAST_ID = 8'hFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [DRVRS*PCKG_SZ-1:0]   D_push,
  output logic                       busy,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic [15:0]                drop_cnt
);

  localparam int IDW = $clog2(DRVRS);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DELIVER} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr;
  logic [PCKG_SZ-1:0]   pkt_buf;
  logic [IDW-1:0]       sel;
  logic                 any_req;
  logic [DRVRS-1:0]     req_sh;
  logic [7:0]           dest;
  logic                 drop;

  // First requester at or above rr_ptr, wrapping modulo DRVRS
  always_comb begin
    sel     = '0;
    any_req = 1'b0;
    req_sh  = '0;
    for (int k = 0; k < DRVRS; k++) begin
      req_sh = pndng >> ((int'(rr_ptr) + k) % DRVRS);
      if (!any_req && req_sh[0]) begin
        any_req = 1'b1;
        sel     = IDW'((int'(rr_ptr) + k) % DRVRS);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req) state_d = S_GRANT;
      S_GRANT:   state_d = S_DELIVER;
      S_DELIVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign dest = pkt_buf[PCKG_SZ-1 -: 8];

  // Strobes decode from registered state only; no path from pndng/D_pop
  always_comb begin
    pop  = '0;
    push = '0;
    for (int i = 0; i < DRVRS; i++) begin
      if (state_q == S_GRANT && grant_id == IDW'(i)) pop[i] = 1'b1;
      if (state_q == S_DELIVER) begin
        if (dest == 8'(i) && dest != BCAST_ID) push[i] = 1'b1;
`ifdef BUS_BCAST_EN
        if (dest == BCAST_ID && grant_id != IDW'(i)) push[i] = 1'b1;
`endif
      end
    end
  end

  assign drop   = (state_q == S_DELIVER) && (push == '0);
  assign busy   = (state_q != S_IDLE);
  assign D_push = {DRVRS{pkt_buf}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id <= '0;
      rr_ptr   <= '0;
      pkt_buf  <= '0;
      drop_cnt <= '0;
    end else begin
      if (state_q == S_IDLE && any_req) grant_id <= sel;
      if (state_q == S_GRANT) begin
        pkt_buf <= PCKG_SZ'(D_pop >> (int'(grant_id) * PCKG_SZ));
        rr_ptr  <= (grant_id == IDW'(DRVRS - 1)) ? '0 : grant_id + 1'b1;
      end
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bs_rtr_rr_bcast.sv
// Self-checking bench for bs_rtr_rr_bcast: vector table of single-packet transfers, a push
// scoreboard, plus directed saturation, reset-in-flight and round-robin sequences.
module tb_bs_rtr_rr_bcast;
  localparam int DRVRS   = 4;
  localparam int PCKG_SZ = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [DRVRS*PCKG_SZ-1:0] D_push;
  logic                     busy;
  logic [1:0]               grant_id;
  logic [15:0]              drop_cnt;

  bs_rtr_rr_bcast #(.DRVRS(DRVRS), .PCKG_SZ(PCKG_SZ), .BCAST_ID(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .busy(busy), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] exp_drop = 16'd0;

  typedef struct { logic [3:0] push; logic [15:0] pkt; } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;

  typedef struct { int src; logic [15:0] pkt; logic [3:0] push; bit drop; } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every push seen must match the oldest expected delivery
  always @(negedge clk) begin
    if (reset === 1'b1 && push !== 4'b0000) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_push: got push=%b expected none", push);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_push_mask", 64'(push), 64'(sb_e.push));
        check("sb_push_data", D_push, {4{sb_e.pkt}});
      end
    end
  end

  task automatic set_src(input int src, input logic [15:0] pkt);
    D_pop = {4{~pkt}};
    D_pop[src*16 +: 16] = pkt;
    pndng = 4'(1 << src);
  endtask

  // Called at a negedge with the DUT idle
  task automatic send_vec(input int src, input logic [15:0] pkt, input logic [3:0] exp_push,
                          input bit drp);
    set_src(src, pkt);
    @(negedge clk);
    check("grant_pop", 64'(pop), 64'(1 << src));
    check("grant_id", 64'(grant_id), 64'(src));
    check("grant_busy", 64'(busy), 64'd1);
    check("grant_no_push", 64'(push), 64'd0);
    pndng = '0;
    if (exp_push != 4'b0000) sb_q.push_back('{exp_push, pkt});
    @(negedge clk);
    check("deliver_push", 64'(push), 64'(exp_push));
    check("deliver_busy", 64'(busy), 64'd1);
    check("deliver_no_pop", 64'(pop), 64'd0);
    if (drp && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    @(negedge clk);
    check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1, 16'h02AB, 4'b0100, 1'b0};
    vecs[1] = '{0, 16'h0711, 4'b0000, 1'b1};
    vecs[2] = '{3, 16'h0312, 4'b1000, 1'b0};
`ifdef BUS_BCAST_EN
    vecs[3] = '{2, 16'hFF55, 4'b1011, 1'b0};
`else
    vecs[3] = '{2, 16'hFF55, 4'b0000, 1'b1};
`endif
    vecs[4] = '{0, 16'h01CD, 4'b0010, 1'b0};
    vecs[5] = '{2, 16'h0400, 4'b0000, 1'b1};

    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    #12;
    check("rst_pop", 64'(pop), 64'd0);
    check("rst_push", 64'(push), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_d_push", D_push, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", 64'({pop, push, busy}), 64'd0);
    end

    for (int v = 0; v < 6; v++)
      send_vec(vecs[v].src, vecs[v].pkt, vecs[v].push, vecs[v].drop);

    // Drop counter saturation
    force dut.drop_cnt = 16'hFFFE;
    #1 release dut.drop_cnt;
    #1 check("preload_drop", 64'(drop_cnt), 64'hFFFE);
    exp_drop = 16'hFFFE;
    @(negedge clk);
    send_vec(0, 16'h0711, 4'b0000, 1'b1);
    send_vec(1, 16'h0922, 4'b0000, 1'b1);
    check("drop_saturated", 64'(drop_cnt), 64'hFFFF);

    // Reset while delivering: push must collapse asynchronously, packet is lost
    set_src(1, 16'h0233);
    @(negedge clk);
    check("rst_mid_pop", 64'(pop), 64'b0010);
    pndng = '0;
    @(posedge clk);
    #1 check("rst_mid_push_before", 64'(push), 64'b0100);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_push_after", 64'(push), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst_mid_d_push", D_push, 64'd0);
    exp_drop = 16'd0;
    @(negedge clk);
    reset = 1'b1;

    // Round robin from a freshly reset pointer, all sources requesting
    pndng = 4'hF;
    D_pop = {16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rr_pop", 64'(pop), 64'(1 << k));
      check("rr_grant_id", 64'(grant_id), 64'(k));
      sb_q.push_back('{4'b0001, 16'(16'h00A0 + k)});
      @(negedge clk);
      @(negedge clk);
    end
    pndng = '0;
    repeat (3) @(negedge clk);
    check("rr_no_extra_grant", 64'(busy), 64'd0);
    check("rr_drop_cnt", 64'(drop_cnt), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bs_rtr_rr_bcast.md
# bs_rtr_rr_bcast

Parametrised successor to the team's bus generator/arbiter: a DRVRS-port packet bus with round-robin arbitration, destination-field routing, optional broadcast, and a saturating drop counter. Each port connects to an external FWFT FIFO on the driver side (pndng/pop/D_pop) and the receive side (push/D_push). The block pops one packet from the granted source and pushes it to the addressed destination(s). It sits between the per-driver FIFOs modelled by the testbench drivers/monitors.

## Interface
- DRVRS, 4, number of ports (2..16)
- PCKG_SZ, 16, packet width in bits (>= 9); bits [PCKG_SZ-1:PCKG_SZ-8] = destination ID, rest payload
- BCAST_ID, 8'hFF, destination ID meaning "all ports except source"
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pndng  in  DRVRS  bit i high = source FIFO i non-empty; D_pop slice i valid
- D_pop  in  DRVRS*PCKG_SZ  head-of-FIFO data, slice i = bits [i*PCKG_SZ +: PCKG_SZ]
- pop  out  DRVRS  one-hot, one-cycle pop strobe to source FIFO
- push  out  DRVRS  push strobe to receive FIFO(s); multi-hot only on broadcast
- D_push  out  DRVRS*PCKG_SZ  every slice carries the same buffered packet
- busy  out  1  high in GRANT or DELIVER
- grant_id  out  $clog2(DRVRS)  index of last granted source
- drop_cnt  out  16  count of dropped packets, saturates at 16'hFFFF

## Operation
- FSM: IDLE -> GRANT -> DELIVER -> IDLE.
- IDLE: if any pndng bit is high, select source g by round-robin starting at rr_ptr and searching upward mod DRVRS. Register g into grant_id and go to GRANT. Otherwise stay in IDLE.
- GRANT: pop[g]=1 for exactly this cycle; latch D_pop slice g into pkt_buf at the closing edge; go to DELIVER; rr_ptr <= (g+1) mod DRVRS.
- DELIVER: decode dest = pkt_buf[PCKG_SZ-1 -: 8].
  - dest < DRVRS: push[dest]=1. A self-addressed packet (dest == g) is delivered to the source.
  - dest == BCAST_ID (broadcast enabled): push[i]=1 for all i != g.
  - Otherwise: no push; drop_cnt increments unless already 16'hFFFF.
  - Go to IDLE.
- D_push: all slices = pkt_buf at all times. The value is meaningful only while push is high.
- pndng changes during GRANT/DELIVER are ignored; re-sampled in IDLE.
- No back-pressure from receive FIFOs; receive-side overflow is the FIFO's concern.

## Timing
- Reset (reset=0, async): state=IDLE, pop=0, push=0, busy=0, grant_id=0, rr_ptr=0, pkt_buf=0, D_push=0, drop_cnt=0. A packet mid-flight is lost. If it was already popped, it is not counted as a drop.
- All outputs are registered or decoded from registered state only; no combinational path from pndng/D_pop to outputs.
- Latency: pndng sampled high at edge N (state IDLE) -> pop high cycle N+1 -> push high cycle N+2.
- Throughput: one packet per 3 cycles. Back-to-back sources are served alternately under round-robin.
- busy is high during the pop and push cycles, low in IDLE.
- Release of reset is synchronous to clk; first grant possible on the first edge after reset goes high.

## Configuration
- BUS_BCAST_EN defined: dest == BCAST_ID broadcasts to all ports except the source.
- BUS_BCAST_EN undefined: BCAST_ID is treated as out of range, so the packet is dropped and drop_cnt increments. The broadcast decode logic is absent.

## Test plan
- Unicast, DRVRS=4: pndng[1]=1, D_pop[1]=16'h02AB -> pop=4'b0010 on cycle+1, push=4'b0100 with D_push slice 2 = 16'h02AB on cycle+2; grant_id=1.
- Round-robin: pndng=4'b1111 held for 12 cycles, all packets addressed to port 0 -> grants in order 0,1,2,3; four pushes to port 0.
- Broadcast (BUS_BCAST_EN defined): port 2 sends 16'hFF55 -> push=4'b1011, D_push=16'hFF55. Same stimulus with the macro undefined -> push=0 and drop_cnt=1.
- Out-of-range: port 0 sends 16'h0711 (dest 7, DRVRS=4) -> no push, drop_cnt 0->1. Preload drop_cnt to 16'hFFFF and send another -> it stays at 16'hFFFF.
- Reset mid-operation: assert reset=0 during the DELIVER cycle -> push drops to 0 immediately (async); after release, state=IDLE, rr_ptr=0, drop_cnt=0.
- Idle: pndng=0 for 20 cycles -> pop=0, push=0, busy=0 throughout.
